pipemem_io: RTL

MEM-stage block of the five-stage pipelined CPU. It sits between the EX/MEM register and the MEM/WB register. It takes the ALU result as the address and the store operand as data. It holds the word-addressed data RAM and the memory-mapped I/O: output ports, synchronized input ports and a free-running timer. Its read result `mmo` feeds the MEM/WB register directly.

---
 rtl/pipemem_io_if.sv | 11 +
 rtl/pipemem_io.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipemem_io_if.sv
// MEM-stage bus between the EX/MEM register and the memory/I-O block:
// address, store data, store enable and the combinational read result.
interface pipemem_io_if;
  logic [31:0] malu;
  logic [31:0] mb;
  logic        mwmem;
  logic [31:0] mmo;

  modport master (output malu, output mb, output mwmem, input mmo);
  modport slave  (input malu, input mb, input mwmem, output mmo);
endinterface

// File: rtl/pipemem_io.sv
// MEM stage of the five-stage CPU: word-addressed data RAM plus memory-mapped
// output registers, two-flop synchronized input ports and a free-running timer.
module pipemem_io #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic            clock,
  input  logic            resetn,
  pipemem_io_if.slave     bus,
  input  logic [31:0]     in_port0,
  input  logic [31:0]     in_port1,
  output logic [31:0]     out_port0,
  output logic [31:0]     out_port1,
  output logic [31:0]     out_port2
);

  // I/O register map, indexed by malu[7:2]
  localparam logic [5:0] IO_OUT0  = 6'h20;  // 0x80
  localparam logic [5:0] IO_OUT1  = 6'h21;  // 0x84
  localparam logic [5:0] IO_OUT2  = 6'h22;  // 0x88
  localparam logic [5:0] IO_IN0   = 6'h30;  // 0xC0
  localparam logic [5:0] IO_IN1   = 6'h31;  // 0xC4
  localparam logic [5:0] IO_TIMER = 6'h32;  // 0xC8

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           ram_r [0:WORDS-1];
  logic [31:0]           out0_r;
  logic [31:0]           out1_r;
  logic [31:0]           out2_r;
  logic [31:0]           sync0_a_r;
  logic [31:0]           sync0_b_r;
  logic [31:0]           sync1_a_r;
  logic [31:0]           sync1_b_r;
  logic [31:0]           timer_r;

  logic                  io_sel_s;
  logic [5:0]            io_reg_s;
  logic [DEPTH_LOG2-1:0] ram_idx_s;
  logic                  ram_we_s;
  logic                  out0_we_s;
  logic                  out1_we_s;
  logic                  out2_we_s;
  logic                  timer_we_s;
  logic [31:0]           mmo_s;
  logic                  unused_s;

  // Byte-offset and high address bits only alias; keep them visibly consumed.
  assign unused_s  = ^bus.malu;

  assign io_sel_s  = bus.malu[7];
  assign io_reg_s  = bus.malu[7:2];
  assign ram_idx_s = bus.malu[DEPTH_LOG2+1:2];

  // Write-enable decode; resetn gates the RAM since it has no reset of its own.
  always_comb begin
    ram_we_s   = 1'b0;
    out0_we_s  = 1'b0;
    out1_we_s  = 1'b0;
    out2_we_s  = 1'b0;
    timer_we_s = 1'b0;
    if (bus.mwmem) begin
      if (io_sel_s) begin
        case (io_reg_s)
          IO_OUT0:  out0_we_s  = 1'b1;
          IO_OUT1:  out1_we_s  = 1'b1;
          IO_OUT2:  out2_we_s  = 1'b1;
          IO_TIMER: timer_we_s = 1'b1;
          default:  ram_we_s   = 1'b0;
        endcase
      end else begin
        ram_we_s = resetn;
      end
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Combinational read path; unmapped and write-only-free holes read as zero.
  always_comb begin
    mmo_s = 32'd0;
    if (io_sel_s) begin
      case (io_reg_s)
        IO_OUT0:  mmo_s = out0_r;
        IO_OUT1:  mmo_s = out1_r;
        IO_OUT2:  mmo_s = out2_r;
        IO_IN0:   mmo_s = sync0_b_r;
        IO_IN1:   mmo_s = sync1_b_r;
        IO_TIMER: mmo_s = timer_r;
        default:  mmo_s = 32'd0;
      endcase
    end else begin
      mmo_s = ram_r[ram_idx_s];
    end
  end

  assign bus.mmo = mmo_s;

  // Data RAM, deliberately without reset.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= bus.mb;
    end
  end

  // Output port registers: change only on the edge that stores to them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out0_r <= 32'd0;
      out1_r <= 32'd0;
      out2_r <= 32'd0;
    end else begin
      if (out0_we_s) out0_r <= bus.mb;
      if (out1_we_s) out1_r <= bus.mb;
      if (out2_we_s) out2_r <= bus.mb;
    end
  end

  // Two-flop synchronizers for the asynchronous input ports.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync0_a_r <= 32'd0;
      sync0_b_r <= 32'd0;
      sync1_a_r <= 32'd0;
      sync1_b_r <= 32'd0;
    end else begin
      sync0_a_r <= in_port0;
      sync0_b_r <= sync0_a_r;
      sync1_a_r <= in_port1;
      sync1_b_r <= sync1_a_r;
    end
  end

  // Free-running timer; a store on the same edge takes priority over the increment.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer_r <= 32'd0;
    end else if (timer_we_s) begin
      timer_r <= bus.mb;
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  assign out_port0 = out0_r;
  assign out_port1 = out1_r;
  assign out_port2 = out2_r;

endmodule
